// File: rtl/md_unit_param.sv
// Multiply/divide unit with HI/LO registers and fixed-latency busy window.
// Operands are captured on accept; results are written on the edge that ends the last busy cycle.
module md_unit_param #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       MDctrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    input  logic             HILOsel,
    output logic             busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] MDout
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic                    is_md_op, accept;
    logic [2*WIDTH-1:0]      prod_s, prod_u;
    logic                    b_zero, div_ovf;
    logic signed [WIDTH-1:0] dvd_s, dvs_s, quo_s, rem_s;
    logic [WIDTH-1:0]        dvs_u, quo_u, rem_u;

    assign is_md_op = (MDctrl >= OP_MULT) && (MDctrl <= OP_DIVU);
    assign accept   = (state_q == S_IDLE) && !cancel && (MDctrl >= OP_MULT) && (MDctrl <= OP_MTLO);

    assign busy     = (state_q == S_BUSY);
    assign md_stall = busy | (is_md_op & ~cancel);
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign MDout    = HILOsel ? hi_q : lo_q;

    // Full-width products from sign- or zero-extended captured operands
    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Dividing most-negative by 1 instead of -1 yields exactly quotient = A, remainder = 0
    assign b_zero  = (b_q == '0);
    assign div_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);
    assign dvd_s   = a_q;
    assign dvs_s   = (b_zero || div_ovf) ? WIDTH'(1) : b_q;
    assign quo_s   = dvd_s / dvs_s;
    assign rem_s   = dvd_s % dvs_s;
    assign dvs_u   = b_zero ? WIDTH'(1) : b_q;
    assign quo_u   = a_q / dvs_u;
    assign rem_u   = a_q % dvs_u;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (MDctrl)
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = MDctrl;
                            cnt_d   = (MDctrl == OP_MULT || MDctrl == OP_MULTU) ?
                                      CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            state_d = S_BUSY;
                        end
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV: begin
                            if (!b_zero) begin
                                lo_d = quo_s;
                                hi_d = rem_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!b_zero) begin
                                lo_d = quo_u;
                                hi_d = rem_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_unit_param.sv
// Bench for md_unit_param: directed corner cases plus random ops against a
// transaction-level HI/LO model using 64-bit integer arithmetic.
module tb_md_unit_param;

    logic        clk;
    logic        reset;
    logic [2:0]  MDctrl;
    logic [31:0] A;
    logic [31:0] B;
    logic        cancel;
    logic        HILOsel;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDout;

    int total;
    int bad;

    // Model state: remaining busy cycles, architectural HI/LO, pending result
    int          m_cnt;
    logic [31:0] m_hi, m_lo;
    logic [31:0] p_hi, p_lo;
    bit          p_wr;

    md_unit_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .MDctrl  (MDctrl),
        .A       (A),
        .B       (B),
        .cancel  (cancel),
        .HILOsel (HILOsel),
        .busy    (busy),
        .md_stall(md_stall),
        .HI      (HI),
        .LO      (LO),
        .MDout   (MDout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa   = $signed(a);
        sb   = $signed(b);
        ua   = a;
        ub   = b;
        p_wr = 1'b1;
        case (op)
            3'd1: begin sp = sa * sb; {p_hi, p_lo} = sp; end
            3'd2: begin up = ua * ub; {p_hi, p_lo} = up; end
            3'd3: begin
                if (b == 32'd0) p_wr = 1'b0;
                else begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
            end
            default: begin
                if (b == 32'd0) p_wr = 1'b0;
                else begin p_lo = 32'(ua / ub); p_hi = 32'(ua % ub); end
            end
        endcase
    endtask

    // One clock cycle: check registered state, drive inputs, check comb outputs, advance model
    task automatic step(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic cn, input logic sel);
        @(negedge clk);
        check("busy", 64'(busy), 64'(m_cnt != 0));
        check("hi", 64'(HI), 64'(m_hi));
        check("lo", 64'(LO), 64'(m_lo));
        MDctrl  = ctrl;
        A       = a;
        B       = b;
        cancel  = cn;
        HILOsel = sel;
        #1;
        check("md_stall", 64'(md_stall), 64'((m_cnt != 0) || (ctrl >= 3'd1 && ctrl <= 3'd4 && !cn)));
        check("mdout", 64'(MDout), 64'(sel ? m_hi : m_lo));
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (!cn && ctrl >= 3'd1 && ctrl <= 3'd6) begin
            case (ctrl)
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: begin
                    m_cnt = (ctrl <= 3'd2) ? 5 : 10;
                    compute(ctrl, a, b);
                end
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'd0, 32'd0, 32'd0, 1'b0, 1'($urandom % 2));
    endtask

    task automatic expect_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        @(negedge clk);
        check({tag, "_hi"}, 64'(HI), 64'(hi));
        check({tag, "_lo"}, 64'(LO), 64'(lo));
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        total   = 0;
        bad     = 0;
        m_cnt   = 0;
        m_hi    = '0;
        m_lo    = '0;
        p_hi    = '0;
        p_lo    = '0;
        p_wr    = 1'b0;
        reset   = 1'b1;
        MDctrl  = 3'd0;
        A       = '0;
        B       = '0;
        cancel  = 1'b0;
        HILOsel = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_hi", 64'(HI), 64'(0));
        check("rst_lo", 64'(LO), 64'(0));
        check("rst_stall", 64'(md_stall), 64'(0));
        reset = 1'b0;

        step(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        idle(5);
        expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        step(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        idle(5);
        expect_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        step(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(10);
        expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        step(3'd4, 32'd7, 32'd2, 1'b0, 1'b0);
        idle(10);
        expect_hilo("divu", 32'd1, 32'd3);

        step(3'd5, 32'h11, 32'd0, 1'b0, 1'b0);
        step(3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
        step(3'd3, 32'd5, 32'd0, 1'b0, 1'b1);
        idle(10);
        expect_hilo("div0", 32'h11, 32'h22);
        step(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(10);
        expect_hilo("divovf", 32'd0, 32'h8000_0000);

        step(3'd6, 32'h1234, 32'd0, 1'b0, 1'b0);
        expect_hilo("mtlo", 32'd0, 32'h1234);
        step(3'd1, 32'd3, 32'd4, 1'b0, 1'b0);
        step(3'd5, 32'hDEAD, 32'd0, 1'b0, 1'b1);
        idle(4);
        expect_hilo("mthi_busy", 32'd0, 32'd12);

        step(3'd1, 32'd5, 32'd6, 1'b1, 1'b0);
        idle(2);
        expect_hilo("cancel_idle", 32'd0, 32'd12);
        step(3'd1, 32'd7, 32'd8, 1'b0, 1'b0);
        step(3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        idle(4);
        expect_hilo("cancel_busy", 32'd0, 32'd56);

        // Reset in the third busy cycle of a mult
        step(3'd5, 32'h55, 32'd0, 1'b0, 1'b0);
        step(3'd1, 32'h12345, 32'h10000, 1'b0, 1'b0);
        step(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_hi", 64'(HI), 64'(0));
        check("midrst_lo", 64'(LO), 64'(0));
        m_cnt = 0;
        m_hi  = '0;
        m_lo  = '0;
        @(negedge clk);
        reset = 1'b0;
        idle(10);
        expect_hilo("post_rst", 32'd0, 32'd0);

        for (int i = 0; i < 800; i++) begin
            step(3'($urandom % 8), rand_opnd(), rand_opnd(),
                 1'(($urandom % 6) == 0), 1'($urandom % 2));
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_unit_param.md
MD_UNIT_PARAM -- requirements
Module: md_unit_param

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width in bits, minimum 2.
REQ-002 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu, minimum 1.
REQ-003 Parameter DIV_CYCLES, default 10, busy cycles for div/divu, minimum 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 MDctrl  input  3  operation: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
REQ-007 A  input  WIDTH  rs operand: dividend / multiplicand / mthi-mtlo source.
REQ-008 B  input  WIDTH  rt operand: divisor / multiplier.
REQ-009 cancel  input  1  exception flush; the op on MDctrl this cycle is not accepted.
REQ-010 HILOsel  input  1  read select: 1 = HI, 0 = LO.
REQ-011 busy  output  1  high while a mult/div is in flight.
REQ-012 md_stall  output  1  high when a new MD op must wait: busy | (MDctrl in 001..100 & ~cancel & ~busy).
REQ-013 HI  output  WIDTH  HI register.
REQ-014 LO  output  WIDTH  LO register.
REQ-015 MDout  output  WIDTH  HILOsel ? HI : LO, combinational.

Function
REQ-016 Accept condition: ~busy & ~cancel & MDctrl in 001..110; all other codes are no-ops.
REQ-017 Accepted mthi/mtlo writes A to HI/LO at that edge; busy stays 0; other register unchanged.
REQ-018 Accepted mult/div captures A, B and opcode at that edge, loads the counter with MULT_CYCLES or DIV_CYCLES and sets busy.
REQ-019 Two-state FSM: IDLE -> BUSY on accepted mult/div; BUSY -> IDLE on the edge where the counter equals 1; the counter decrements once per busy cycle.
REQ-020 busy is high for exactly N consecutive cycles after the accept edge; HI/LO update on the edge that ends the last busy cycle.
REQ-021 HI/LO hold their old values for the whole busy window; MDout during busy shows the old values.
REQ-022 mult: signed 2*WIDTH product; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-023 multu: unsigned 2*WIDTH product, same split as mult.
REQ-024 div: LO = signed quotient truncated toward zero; HI = remainder, sign of dividend.
REQ-025 div with A = most-negative and B = -1: LO = most-negative, HI = 0.
REQ-026 divu: LO = unsigned quotient, HI = unsigned remainder.
REQ-027 Divisor 0 (div or divu): full busy window is still taken; HI and LO are left unchanged at completion.
REQ-028 Any MDctrl presented while busy (including mthi/mtlo) is ignored; md_stall stays high so the pipeline holds it.
REQ-029 cancel has no effect on an op already in flight; it completes and writes normally.
REQ-030 cancel suppresses acceptance only in the cycle it is asserted.

Reset
REQ-031 While reset is high: busy = 0, counter = 0, FSM = IDLE, HI = 0, LO = 0, captured operands = 0.
REQ-032 reset asserted mid-operation aborts the op immediately; no HI/LO write occurs after release.
REQ-033 First accept is possible on the first rising edge after reset deasserts.

Verification (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10)
REQ-034 mult A=0xFFFFFFFF, B=2 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-035 div A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-036 Preload HI=0x11, LO=0x22 via mthi/mtlo; then div with B=0 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged; div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 mtlo A=0x1234 while idle -> LO=0x1234 after one edge, busy stays 0; mthi while busy -> HI unchanged, md_stall=1.
REQ-038 MDctrl=001 with cancel=1 -> busy stays 0, HI/LO unchanged, md_stall=0; cancel pulsed during busy -> result still written at the end of the window.
REQ-039 Reset pulsed in the 3rd busy cycle of a mult -> busy=0 and HI=LO=0 immediately, and both stay 0 for 10 cycles after release.
